usb_rx: RTL and testbench

USB_RX -- requirements
Module: usb_rx

---
 rtl/usb_rx_if.sv | 41 ++++
 rtl/usb_rx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_usb_rx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_if.sv
// ---------------------------------------------------------------------------
// usb_rx_if -- bundle of the USB receiver's line inputs and packet outputs.
//
// Signals:
//   dplus_in, dminus_in   raw D+/D- bus lines (asynchronous to the receiver clock)
//   buffer_occupancy      current receive FIFO byte count, 0..64
//   rx_packet_data        received data byte, valid while store_rx_packet_data=1
//   store_rx_packet_data  one-cycle push strobe toward the FIFO
//   rx_packet             decoded PID code (0 none,1 OUT,2 IN,3 DATA0,4 DATA1,
//                         5 ACK,6 NAK,7 STALL)
//   rx_data_ready         one-cycle pulse at the end of a clean packet
//   rx_transfer_active    high while a packet is being received
//   rx_error              sticky error flag, cleared by the next packet start
//
// Modports:
//   slave  -- the receiver (consumes line/occupancy, drives results)
//   master -- the environment (drives line/occupancy, observes results)
// ---------------------------------------------------------------------------
interface usb_rx_if;
  logic       dplus_in;
  logic       dminus_in;
  logic [6:0] buffer_occupancy;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;
  logic [2:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;

  modport slave (
    input  dplus_in, dminus_in, buffer_occupancy,
    output rx_packet_data, store_rx_packet_data, rx_packet,
           rx_data_ready, rx_transfer_active, rx_error
  );

  modport master (
    output dplus_in, dminus_in, buffer_occupancy,
    input  rx_packet_data, store_rx_packet_data, rx_packet,
           rx_data_ready, rx_transfer_active, rx_error
  );
endinterface

// File: rtl/usb_rx.sv
// ---------------------------------------------------------------------------
// usb_rx -- USB packet receiver: synchronizes D+/D-, recovers bit timing from
// D+ transitions, NRZI-decodes, checks SYNC and PID, pushes DATA payload bytes
// to a FIFO and validates the end-of-packet (SE0, SE0, J).
//
// Ports:
//   clk   sole clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   usb_rx_if.slave: line inputs, FIFO occupancy, decoded outputs
//
// Parameter:
//   CLKS_PER_BIT  clk cycles per USB bit time (even, >= 4)
//
// Build option:
//   USB_RX_BITSTUFF_EN  when defined, the bit following six consecutive
//                       decoded 1s is removed, and a 1 in that slot is an error.
// ---------------------------------------------------------------------------
module usb_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic    clk,
  input  logic    rst,
  usb_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] WRAP_AT   = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP, ERR} state_t;

  state_t r_state;
  state_t w_nextState;

  logic             r_dpMeta, r_dpSync, r_dpLast;
  logic             r_dmMeta, r_dmSync;
  logic [CNT_W-1:0] r_bitTimer;
  logic             r_prevLevel;
  logic [6:0]       r_shift;
  logic [2:0]       r_bitCount;
  logic [1:0]       r_se0Count;
  logic [2:0]       r_idleCount;
`ifdef USB_RX_BITSTUFF_EN
  logic [2:0]       r_onesCount;
`endif

  logic [7:0] r_data;
  logic       r_store;
  logic [2:0] r_packet;
  logic       r_ready;
  logic       r_active;
  logic       r_error;

  logic       w_edge, w_fall, w_sample, w_se0, w_isJ, w_bit;
  logic [7:0] w_byte;
  logic       w_keep, w_stuffErr, w_byteDone, w_decode;
  logic [2:0] w_pidCode;
  logic       w_pidOk, w_pidIsData, w_full;
  logic       w_start, w_storeNow, w_loadPid, w_finish;

  // Map the PID type nibble to the external packet code; 0 means "not a PID
  // this receiver accepts".
  function automatic logic [2:0] pidCode(input logic [3:0] nibble);
    case (nibble)
      4'h1:    pidCode = 3'd1;
      4'h9:    pidCode = 3'd2;
      4'h3:    pidCode = 3'd3;
      4'hB:    pidCode = 3'd4;
      4'h2:    pidCode = 3'd5;
      4'hA:    pidCode = 3'd6;
      4'hE:    pidCode = 3'd7;
      default: pidCode = 3'd0;
    endcase
  endfunction

  // An edge landing on the sample point restarts the timer and suppresses the
  // sample, so the bit is always taken mid-cell, never on a transition.
  assign w_edge   = r_dpSync ^ r_dpLast;
  assign w_fall   = r_dpLast & ~r_dpSync;
  assign w_sample = ~w_edge & (r_bitTimer == SAMPLE_AT);
  assign w_se0    = ~r_dpSync & ~r_dmSync;
  assign w_isJ    = r_dpSync & ~r_dmSync;
  assign w_bit    = (r_dpSync == r_prevLevel);
  assign w_byte   = {w_bit, r_shift};

`ifdef USB_RX_BITSTUFF_EN
  assign w_keep     = (r_onesCount != 3'd6);
  assign w_stuffErr = (r_onesCount == 3'd6) & w_bit;
`else
  assign w_keep     = 1'b1;
  assign w_stuffErr = 1'b0;
`endif

  assign w_byteDone  = w_keep & (r_bitCount == 3'd7);
  assign w_decode    = w_sample & ~w_se0 &
                       ((r_state == SYNC) | (r_state == PID) | (r_state == DATA));
  assign w_pidCode   = pidCode(w_byte[3:0]);
  assign w_pidOk     = (w_byte[7:4] == ~w_byte[3:0]) & (w_pidCode != 3'd0);
  assign w_pidIsData = (w_byte[3:0] == 4'h3) | (w_byte[3:0] == 4'hB);
  assign w_full      = (bus.buffer_occupancy == 7'd64);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state and per-cycle control decisions; all decisions except packet
  // start happen only on a bit sample.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_storeNow  = 1'b0;
    w_loadPid   = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_nextState = SYNC;
          w_start     = 1'b1;
        end
      end
      SYNC: begin
        if (w_sample) begin
          if (w_se0 || w_stuffErr) w_nextState = ERR;
          else if (w_byteDone)     w_nextState = (w_byte == 8'h80) ? PID : ERR;
        end
      end
      PID: begin
        if (w_sample) begin
          if (w_se0 || w_stuffErr) w_nextState = ERR;
          else if (w_byteDone) begin
            if (w_pidOk) begin
              w_loadPid   = 1'b1;
              w_nextState = w_pidIsData ? DATA : EOP;
            end else begin
              w_nextState = ERR;
            end
          end
        end
      end
      DATA: begin
        if (w_sample) begin
          if (w_se0)           w_nextState = (r_bitCount == 3'd0) ? EOP : ERR;
          else if (w_stuffErr) w_nextState = ERR;
          else if (w_byteDone) begin
            if (w_full) w_nextState = ERR;
            else        w_storeNow  = 1'b1;
          end
        end
      end
      EOP: begin
        // Needs exactly two SE0 bit times, then a J.
        if (w_sample) begin
          if (w_se0) begin
            if (r_se0Count == 2'd2) w_nextState = ERR;
          end else if (w_isJ && (r_se0Count == 2'd2)) begin
            w_finish    = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_nextState = ERR;
          end
        end
      end
      ERR: begin
        if (w_sample && w_isJ && (r_idleCount == 3'd7)) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Synchronizers, bit timer, NRZI/shift datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dpMeta    <= 1'b1;
      r_dpSync    <= 1'b1;
      r_dpLast    <= 1'b1;
      r_dmMeta    <= 1'b0;
      r_dmSync    <= 1'b0;
      r_bitTimer  <= '0;
      r_prevLevel <= 1'b1;
      r_shift     <= '0;
      r_bitCount  <= '0;
      r_se0Count  <= '0;
      r_idleCount <= '0;
`ifdef USB_RX_BITSTUFF_EN
      r_onesCount <= '0;
`endif
      r_data      <= '0;
      r_store     <= 1'b0;
      r_packet    <= '0;
      r_ready     <= 1'b0;
      r_active    <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_dpMeta <= bus.dplus_in;
      r_dpSync <= r_dpMeta;
      r_dpLast <= r_dpSync;
      r_dmMeta <= bus.dminus_in;
      r_dmSync <= r_dmMeta;

      if (w_edge || (r_bitTimer == WRAP_AT)) r_bitTimer <= '0;
      else                                   r_bitTimer <= r_bitTimer + CNT_W'(1);

      r_store <= w_storeNow;
      r_ready <= w_finish;
      if (w_storeNow) r_data <= w_byte;

      // The NRZI reference level tracks every sampled bit, stuffed or not.
      if (w_decode) begin
        r_prevLevel <= r_dpSync;
        if (w_keep) begin
          r_shift    <= w_byte[7:1];
          r_bitCount <= r_bitCount + 3'd1;
        end
      end

`ifdef USB_RX_BITSTUFF_EN
      if (w_decode) r_onesCount <= (w_keep && w_bit) ? r_onesCount + 3'd1 : 3'd0;
`endif

      // SE0 that ended DATA already counts as the first EOP bit time.
      if ((r_state == DATA) && (w_nextState == EOP))
        r_se0Count <= 2'd1;
      else if ((r_state == EOP) && w_sample && w_se0)
        r_se0Count <= r_se0Count + 2'd1;

      if ((r_state != ERR) && (w_nextState == ERR)) begin
        r_error     <= 1'b1;
        r_active    <= 1'b0;
        r_idleCount <= '0;
      end else if ((r_state == ERR) && w_sample) begin
        r_idleCount <= w_isJ ? r_idleCount + 3'd1 : 3'd0;
      end

      if (w_start) begin
        r_prevLevel <= 1'b1;
        r_shift     <= '0;
        r_bitCount  <= '0;
        r_se0Count  <= '0;
`ifdef USB_RX_BITSTUFF_EN
        r_onesCount <= '0;
`endif
        r_active    <= 1'b1;
        r_error     <= 1'b0;
        r_packet    <= '0;
      end

      if (w_loadPid) r_packet <= w_pidCode;
      if (w_finish)  r_active <= 1'b0;
    end
  end

  assign bus.rx_packet_data       = r_data;
  assign bus.store_rx_packet_data = r_store;
  assign bus.rx_packet            = r_packet;
  assign bus.rx_data_ready        = r_ready;
  assign bus.rx_transfer_active   = r_active;
  assign bus.rx_error             = r_error;

endmodule

// File: tb/tb_usb_rx.sv
// ---------------------------------------------------------------------------
// tb_usb_rx -- self-checking bench for usb_rx. Packets are NRZI-encoded
// (with bit stuffing when USB_RX_BITSTUFF_EN is defined) onto D+/D-; results
// are compared against hand-written vector expectations and against a
// packet-level reference model for randomized packets.
// ---------------------------------------------------------------------------
module tb_usb_rx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;

  usb_rx_if bus ();

  usb_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pid;
    int          nBytes;
    logic [31:0] data;
    logic [6:0]  occ;
    int          partialBits;
    int          se0Bits;
    logic [2:0]  expPacket;
    int          expReady;
    logic        expError;
    int          expStores;
  } vec_t;

  int         compareCount = 0;
  int         failCount    = 0;
  logic [7:0] storeQ[$];
  int         readyCount   = 0;
  logic       txLevel;
  int         txOnes;
  logic       forceStuffOne = 1'b0;

  // Record every strobed byte and every ready pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.store_rx_packet_data === 1'b1) storeQ.push_back(bus.rx_packet_data);
    if (bus.rx_data_ready === 1'b1) readyCount++;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveLine(input logic dp, input logic dm);
    bus.dplus_in  = dp;
    bus.dminus_in = dm;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    if (!b) txLevel = ~txLevel;
    driveLine(txLevel, ~txLevel);
`ifdef USB_RX_BITSTUFF_EN
    txOnes = b ? txOnes + 1 : 0;
    if (txOnes == 6) begin
      if (!forceStuffOne) txLevel = ~txLevel;
      driveLine(txLevel, ~txLevel);
      txOnes = 0;
    end
`endif
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
  endtask

  // Send SYNC, PID, payload, optional partial byte, SE0s, J, then idle J.
  task automatic applyStimulus(input string tag, input vec_t v);
    bus.buffer_occupancy = v.occ;
    txLevel = 1'b1;
    txOnes  = 0;
    sendByte(8'h80);
    checkOutput($sformatf("%s.activeInPacket", tag), {31'd0, bus.rx_transfer_active}, 32'd1);
    checkOutput($sformatf("%s.errorClearedAtStart", tag), {31'd0, bus.rx_error}, 32'd0);
    checkOutput($sformatf("%s.pidClearedAtStart", tag), {29'd0, bus.rx_packet}, 32'd0);
    sendByte(v.pid);
    for (int i = 0; i < v.nBytes; i++) sendByte(v.data[8*i +: 8]);
    for (int i = 0; i < v.partialBits; i++) sendBit(i[0]);
    for (int i = 0; i < v.se0Bits; i++) driveLine(1'b0, 1'b0);
    driveLine(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) driveLine(1'b1, 1'b0);
  endtask

  task automatic runVector(input string tag, input vec_t v);
    int storeStart;
    int readyStart;
    int nGot;
    storeStart = storeQ.size();
    readyStart = readyCount;
    applyStimulus(tag, v);
    nGot = storeQ.size() - storeStart;
    checkOutput($sformatf("%s.rx_packet", tag), {29'd0, bus.rx_packet}, {29'd0, v.expPacket});
    checkOutput($sformatf("%s.readyPulses", tag), readyCount - readyStart, v.expReady);
    checkOutput($sformatf("%s.rx_error", tag), {31'd0, bus.rx_error}, {31'd0, v.expError});
    checkOutput($sformatf("%s.activeAfter", tag), {31'd0, bus.rx_transfer_active}, 32'd0);
    checkOutput($sformatf("%s.storeCount", tag), nGot, v.expStores);
    for (int i = 0; i < v.expStores && i < nGot; i++)
      checkOutput($sformatf("%s.storeByte%0d", tag, i), {24'd0, storeQ[storeStart+i]},
                  {24'd0, v.data[8*i +: 8]});
  endtask

  // Packet-level reference: PID must be a known type with a correct check
  // nibble; DATA packets push each byte unless the FIFO is full.
  task automatic refModel(inout vec_t v);
    logic [2:0] pidMap [16];
    logic [2:0] code;
    for (int i = 0; i < 16; i++) pidMap[i] = 3'd0;
    pidMap[4'h1] = 3'd1; pidMap[4'h9] = 3'd2; pidMap[4'h3] = 3'd3; pidMap[4'hB] = 3'd4;
    pidMap[4'h2] = 3'd5; pidMap[4'hA] = 3'd6; pidMap[4'hE] = 3'd7;
    code = pidMap[v.pid[3:0]];
    v.expStores = 0;
    if ((v.pid[7:4] != ~v.pid[3:0]) || (code == 3'd0)) begin
      v.expPacket = 3'd0;
      v.expError  = 1'b1;
      v.expReady  = 0;
    end else begin
      v.expPacket = code;
      v.expError  = 1'b0;
      for (int i = 0; i < v.nBytes; i++) begin
        if (v.occ == 7'd64) begin
          v.expError = 1'b1;
          break;
        end
        v.expStores++;
      end
      v.expReady = v.expError ? 0 : 1;
    end
  endtask

  initial begin
    vec_t       vecs [14];
    vec_t       rv;
    logic [7:0] validPids [7];
    logic [7:0] partByte;
    int         storeStart;
    int         readyStart;

    vecs[0]  = '{8'hD2, 0, 32'h0,        7'd10, 0, 2, 3'd5, 1, 1'b0, 0};
    vecs[1]  = '{8'hC3, 2, 32'h0000_00A5, 7'd10, 0, 2, 3'd3, 1, 1'b0, 2};
    vecs[2]  = '{8'hC4, 0, 32'h0,        7'd10, 0, 2, 3'd0, 0, 1'b1, 0};
    vecs[3]  = '{8'h5A, 0, 32'h0,        7'd10, 0, 2, 3'd6, 1, 1'b0, 0};
    vecs[4]  = '{8'h4B, 1, 32'hFF,       7'd64, 0, 2, 3'd4, 0, 1'b1, 0};
    vecs[5]  = '{8'h1E, 0, 32'h0,        7'd10, 0, 2, 3'd7, 1, 1'b0, 0};
    vecs[6]  = '{8'hE1, 0, 32'h0,        7'd10, 0, 2, 3'd1, 1, 1'b0, 0};
    vecs[7]  = '{8'h69, 0, 32'h0,        7'd10, 0, 2, 3'd2, 1, 1'b0, 0};
    vecs[8]  = '{8'h4B, 1, 32'h3C,       7'd63, 0, 2, 3'd4, 1, 1'b0, 1};
    vecs[9]  = '{8'hD3, 0, 32'h0,        7'd10, 0, 2, 3'd0, 0, 1'b1, 0};
    vecs[10] = '{8'hD2, 0, 32'h0,        7'd10, 0, 1, 3'd5, 0, 1'b1, 0};
    vecs[11] = '{8'hC3, 1, 32'hA5,       7'd10, 3, 2, 3'd3, 0, 1'b1, 1};
    vecs[12] = '{8'hD2, 0, 32'h0,        7'd10, 0, 3, 3'd5, 0, 1'b1, 0};
    vecs[13] = '{8'hC3, 0, 32'h0,        7'd64, 0, 2, 3'd3, 1, 1'b0, 0};

    validPids = '{8'hE1, 8'h69, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E};

    // Reset with the line idle; every output must read zero.
    rst = 1'b1;
    bus.dplus_in = 1'b1;
    bus.dminus_in = 1'b0;
    bus.buffer_occupancy = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.rx_packet_data", {24'd0, bus.rx_packet_data}, 32'd0);
    checkOutput("reset.store", {31'd0, bus.store_rx_packet_data}, 32'd0);
    checkOutput("reset.rx_packet", {29'd0, bus.rx_packet}, 32'd0);
    checkOutput("reset.ready", {31'd0, bus.rx_data_ready}, 32'd0);
    checkOutput("reset.active", {31'd0, bus.rx_transfer_active}, 32'd0);
    checkOutput("reset.error", {31'd0, bus.rx_error}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) driveLine(1'b1, 1'b0);

    $display("[TB] directed vectors");
    for (int i = 0; i < 14; i++) runVector($sformatf("vec%0d", i), vecs[i]);

`ifdef USB_RX_BITSTUFF_EN
    $display("[TB] bit stuffing");
    runVector("stuff7F", '{8'hC3, 1, 32'h7F, 7'd10, 0, 2, 3'd3, 1, 1'b0, 1});
    forceStuffOne = 1'b1;
    runVector("stuffErr", '{8'hC3, 1, 32'h7F, 7'd10, 0, 2, 3'd3, 0, 1'b1, 0});
    forceStuffOne = 1'b0;
`endif

    // Reset in the middle of a DATA byte: clean abort, then a clean packet.
    $display("[TB] reset mid-packet");
    bus.buffer_occupancy = 7'd10;
    txLevel = 1'b1;
    txOnes  = 0;
    partByte = 8'hA5;
    storeStart = storeQ.size();
    readyStart = readyCount;
    sendByte(8'h80);
    sendByte(8'hC3);
    for (int i = 0; i < 4; i++) sendBit(partByte[i]);
    checkOutput("midReset.activeBefore", {31'd0, bus.rx_transfer_active}, 32'd1);
    bus.dplus_in  = 1'b1;
    bus.dminus_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midReset.rx_packet_data", {24'd0, bus.rx_packet_data}, 32'd0);
    checkOutput("midReset.store", {31'd0, bus.store_rx_packet_data}, 32'd0);
    checkOutput("midReset.rx_packet", {29'd0, bus.rx_packet}, 32'd0);
    checkOutput("midReset.ready", {31'd0, bus.rx_data_ready}, 32'd0);
    checkOutput("midReset.active", {31'd0, bus.rx_transfer_active}, 32'd0);
    checkOutput("midReset.error", {31'd0, bus.rx_error}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) driveLine(1'b1, 1'b0);
    checkOutput("midReset.noStores", storeQ.size() - storeStart, 32'd0);
    checkOutput("midReset.noReady", readyCount - readyStart, 32'd0);
    checkOutput("midReset.errorAfter", {31'd0, bus.rx_error}, 32'd0);
    runVector("afterReset", '{8'hD2, 0, 32'h0, 7'd10, 0, 2, 3'd5, 1, 1'b0, 0});

    // Randomized packets against the reference model.
    $display("[TB] random packets");
    for (int n = 0; n < 24; n++) begin
      rv.pid = (($urandom_range(0, 5) == 0) ? 8'($urandom) : validPids[$urandom_range(0, 6)]);
      rv.nBytes = ((rv.pid == 8'hC3) || (rv.pid == 8'h4B)) ? $urandom_range(0, 3) : 0;
      rv.data = $urandom;
      rv.occ = ($urandom_range(0, 3) == 0) ? 7'd64 : 7'($urandom_range(0, 63));
      rv.partialBits = 0;
      rv.se0Bits = 2;
      refModel(rv);
      runVector($sformatf("rand%0d", n), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
